// File: rtl/ioctl_upload_responder_if.sv
// Signal bundle between hps_io / RAM mux and the ioctl upload read responder.
// master drives the HPS strobes, the window and RAM read data; slave is the responder.
interface ioctl_upload_responder_if #(
  parameter int unsigned AW = 12
);
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic          ioctl_rd;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          win;
  logic          ram_access;
  logic [AW-1:0] ram_address;
  logic          ram_rd;
  logic [7:0]    ram_data;
  logic          overrun;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, win, ram_data,
    input  ioctl_din, ioctl_wait, ram_access, ram_address, ram_rd, overrun
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr, win, ram_data,
    output ioctl_din, ioctl_wait, ram_access, ram_address, ram_rd, overrun
  );
endinterface

// File: rtl/ioctl_upload_responder.sv
// Answers HPS upload read strobes with bytes from work RAM, claiming the RAM port
// only inside the core's safe window and stalling the HPS until the byte is ready.
module ioctl_upload_responder #(
  parameter int unsigned AW      = 12,
  parameter int unsigned RAM_LAT = 1,
  parameter logic [7:0]  INDEX   = 8'd4,
  parameter logic [7:0]  FILL    = 8'hFF
) (
  input logic                    clk,
  input logic                    reset,
  ioctl_upload_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WAITWIN, ACQ, READ, CAPT} state_t;

  localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

  state_t      state;
  logic [24:0] addr;
  logic [1:0]  lat_cnt;
  logic        upload_q;
  logic        accept;
  logic        out_of_range;

  assign accept       = bus.ioctl_rd & bus.ioctl_upload & (bus.ioctl_index == INDEX);
  assign out_of_range = |addr[24:AW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      addr            <= '0;
      lat_cnt         <= '0;
      upload_q        <= 1'b0;
      bus.ioctl_din   <= '0;
      bus.ioctl_wait  <= 1'b0;
      bus.ram_access  <= 1'b0;
      bus.ram_address <= '0;
      bus.ram_rd      <= 1'b0;
      bus.overrun     <= 1'b0;
    end else begin
      upload_q   <= bus.ioctl_upload;
      bus.ram_rd <= 1'b0;

      // A busy strobe outranks the session-start clear if both land together.
      if (bus.ioctl_upload && !upload_q)
        bus.overrun <= 1'b0;
      if (state != IDLE && bus.ioctl_rd)
        bus.overrun <= 1'b1;

      if (state != IDLE && !bus.ioctl_upload) begin
        state          <= IDLE;
        bus.ioctl_wait <= 1'b0;
        bus.ram_access <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              addr           <= bus.ioctl_addr;
              bus.ioctl_wait <= 1'b1;
              state          <= WAITWIN;
            end
          end
          WAITWIN: begin
            // Out-of-range reads never touch the RAM, so they need no window.
            if (out_of_range) begin
              bus.ioctl_din  <= FILL;
              bus.ioctl_wait <= 1'b0;
              state          <= IDLE;
            end else if (bus.win) begin
              bus.ram_access  <= 1'b1;
              bus.ram_address <= addr[AW-1:0];
              state           <= ACQ;
            end
          end
          ACQ: begin
            bus.ram_rd <= 1'b1;
            lat_cnt    <= LAT_M1;
            state      <= READ;
          end
          READ: begin
            if (lat_cnt == 2'd0)
              state <= CAPT;
            else
              lat_cnt <= lat_cnt - 2'd1;
          end
          CAPT: begin
            bus.ioctl_din  <= bus.ram_data;
            bus.ioctl_wait <= 1'b0;
            bus.ram_access <= 1'b0;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ioctl_upload_responder.sv
// Directed + randomized bench for ioctl_upload_responder against a byte-array RAM
// and a cycle-count reference model of the upload read handshake.
module tb_ioctl_upload_responder;

  localparam int unsigned AW      = 12;
  localparam int unsigned RAM_LAT = 1;
  localparam int unsigned DEPTH   = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   guard_viol = 0;
  logic prev_access = 1'b0;
  logic [7:0] mem [DEPTH];

  ioctl_upload_responder_if #(.AW(AW)) bus ();

  ioctl_upload_responder #(
    .AW(AW), .RAM_LAT(RAM_LAT), .INDEX(8'd4), .FILL(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.ram_rd) bus.ram_data <= mem[bus.ram_address];

  always @(negedge clk) begin
    if (bus.ram_rd && !prev_access) guard_viol++;
    prev_access = bus.ram_access;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [24:0] a);
    logic [AW-1:0] idx;
    idx = a[AW-1:0];
    return (a < 25'(DEPTH)) ? mem[idx] : 8'hFF;
  endfunction

  // Strobe at address a; win is held low until the g-th cycle after the strobe.
  task automatic run_read(input logic [24:0] a, input int g,
                          output int wait_n, output int acc_n, output int rd_n,
                          output int first_rd, output int acc_early);
    int j;
    j = 0; wait_n = 0; acc_n = 0; rd_n = 0; first_rd = -1; acc_early = 0;
    bus.ioctl_addr = a;
    bus.ioctl_rd   = 1'b1;
    if (g > 1) bus.win = 1'b0;
    do begin
      @(negedge clk);
      j++;
      if (j == 1) bus.ioctl_rd = 1'b0;
      if (bus.ioctl_wait) wait_n++;
      if (bus.ram_access) begin
        acc_n++;
        if (j <= g) acc_early++;
      end
      if (bus.ram_rd) begin
        rd_n++;
        if (first_rd < 0) first_rd = j;
      end
      if (j == g) bus.win = 1'b1;
    end while (bus.ioctl_wait && j < 200);
    bus.win = 1'b1;
  endtask

  task automatic check_read(input string tag, input logic [24:0] a, input int g);
    int wn, an, rn, fr, ae;
    bit in_range;
    in_range = (a < 25'(DEPTH));
    run_read(a, g, wn, an, rn, fr, ae);
    chk({tag, "_released"}, bus.ioctl_wait, 0);
    chk({tag, "_din"}, bus.ioctl_din, exp_byte(a));
    chk({tag, "_wait_cycles"}, wn, in_range ? g + 2 + RAM_LAT : 1);
    chk({tag, "_access_cycles"}, an, in_range ? 2 + RAM_LAT : 0);
    chk({tag, "_rd_pulses"}, rn, in_range ? 1 : 0);
    if (in_range) begin
      chk({tag, "_rd_cycle"}, fr, g + 2);
      chk({tag, "_no_early_access"}, ae, 0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_din"}, bus.ioctl_din, 0);
    chk({tag, "_wait"}, bus.ioctl_wait, 0);
    chk({tag, "_access"}, bus.ram_access, 0);
    chk({tag, "_address"}, 32'(bus.ram_address), 0);
    chk({tag, "_ram_rd"}, bus.ram_rd, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
  endtask

  initial begin
    logic [7:0]  prev;
    logic [24:0] a;
    int          cnt;
    int          rn;

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'($urandom);
    mem[12'h123] = 8'h5A;
    mem[12'h010] = 8'h33;

    bus.ioctl_upload = 1'b0;
    bus.ioctl_index  = 8'd4;
    bus.ioctl_rd     = 1'b0;
    bus.ioctl_addr   = '0;
    bus.win          = 1'b1;
    bus.ram_data     = '0;

    #2 reset = 1'b1;
    #1 check_reset_values("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bus.ioctl_upload = 1'b1;
    repeat (2) @(negedge clk);

    check_read("basic_123", 25'h123, 1);
    check_read("win_late_010", 25'h010, 20);
    check_read("oor_1000", 25'h1000, 1);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        a = 25'(DEPTH) + 25'($urandom_range(0, 32'h1FF_FFFF - DEPTH));
        check_read("rand_oor", a, 1);
      end else begin
        a = 25'($urandom_range(0, DEPTH - 1));
        check_read("rand_in", a, $urandom_range(1, 6));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Back-to-back strobes: second must be ignored and flagged.
    chk("overrun_idle", bus.overrun, 0);
    bus.ioctl_addr = 25'h200; bus.ioctl_rd = 1'b1;
    @(negedge clk);
    bus.ioctl_addr = 25'h300;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    cnt = 0; rn = 0;
    while (bus.ioctl_wait && cnt < 200) begin
      if (bus.ram_rd) rn++;
      @(negedge clk);
      cnt++;
    end
    chk("overrun_released", bus.ioctl_wait, 0);
    chk("overrun_set", bus.overrun, 1);
    chk("overrun_one_read", rn, 1);
    chk("overrun_din", bus.ioctl_din, exp_byte(25'h200));
    bus.ioctl_upload = 1'b0;
    @(negedge clk);
    chk("overrun_held_no_session", bus.overrun, 1);
    bus.ioctl_upload = 1'b1;
    @(negedge clk);
    chk("overrun_cleared", bus.overrun, 0);

    // Session abort while the RAM read strobe is out.
    prev = bus.ioctl_din;
    mem[12'h456] = ~prev;
    bus.ioctl_addr = 25'h456; bus.ioctl_rd = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_in_read", bus.ram_rd, 1);
    bus.ioctl_upload = 1'b0;
    @(negedge clk);
    chk("abort_wait", bus.ioctl_wait, 0);
    chk("abort_access", bus.ram_access, 0);
    chk("abort_ram_rd", bus.ram_rd, 0);
    chk("abort_din_kept", bus.ioctl_din, prev);
    bus.ioctl_upload = 1'b1;
    @(negedge clk);
    check_read("after_abort", 25'h456, 1);

    // Foreign index is ignored.
    prev = bus.ioctl_din;
    bus.ioctl_index = 8'd0;
    bus.ioctl_addr = 25'h055; bus.ioctl_rd = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    cnt = 0;
    repeat (6) begin
      if (bus.ioctl_wait || bus.ram_access) cnt++;
      @(negedge clk);
    end
    chk("index0_no_response", cnt, 0);
    chk("index0_din_kept", bus.ioctl_din, prev);
    chk("index0_no_overrun", bus.overrun, 0);
    bus.ioctl_index = 8'd4;

    // Asynchronous reset while the RAM port is claimed.
    bus.ioctl_addr = 25'h777; bus.ioctl_rd = 1'b1;
    @(negedge clk);
    bus.ioctl_rd = 1'b0;
    @(negedge clk);
    chk("acq_access_before_reset", bus.ram_access, 1);
    reset = 1'b1;
    #1 check_reset_values("reset_in_acq");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_read("after_reset", 25'h777, 1);
    check_read("after_reset_late", 25'(($urandom_range(0, DEPTH - 1))), 3);

    chk("ram_rd_guard", guard_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
